bit_serializer: RTL and testbench



---
 rtl/bit_serializer_if.sv | 37 +++
 rtl/bit_serializer.sv | 150 +++++++++++++++
 tb/tb_bit_serializer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Word handshake and serial-bit bundle between a word source, the serializer
// and the downstream sequence detector.
//   word_in     source -> serializer  parallel word
//   word_valid  source -> serializer  word_in holds a word
//   word_ready  serializer -> source  holding register can take a word
//   flush       source -> serializer  synchronous abort of current/pending word
//   in_bit      serializer -> detector serial bit
//   bit_valid   serializer -> detector in_bit carries data this cycle
//   frame_start serializer -> detector first bit of a word
//   frame_done  serializer -> detector last bit of a word
//   busy        serializer -> source  shifting or a word is pending
// -----------------------------------------------------------------------------
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             flush;
  logic             in_bit;
  logic             bit_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output word_in, word_valid, flush,
    input  word_ready, in_bit, bit_valid, frame_start, frame_done, busy
  );

  modport slave (
    input  word_in, word_valid, flush,
    output word_ready, in_bit, bit_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial front end for the bit-stream sequence detector. Words
// arrive over a valid/ready handshake into a one-word holding register and are
// shifted out one bit per clock. Reloading from the holding register on the
// last bit lets consecutive words stream without an idle cycle.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-low
//   bus    bit_serializer_if.slave (word handshake, flush, serial outputs)
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   IDLE_BIT   value on in_bit when no data bit is valid
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing shifting; a pending word is loaded on the next edge
// S_SHIFT | r_sh holds the word in flight, r_cnt is the current bit index
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic          clk,
  input logic          reset,
  bit_serializer_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [WIDTH-1:0] w_sh_shifted;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_hold_full;
  logic             w_hold_full_nxt;
  logic             w_word_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_out_bit;

  // The output end of the shift register depends on bit order; shifting
  // always moves the next bit toward that end.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_sh_shifted = {r_sh[WIDTH-2:0], 1'b0};
      assign w_out_bit    = r_sh[WIDTH-1];
    end else begin : g_lsb
      assign w_sh_shifted = {1'b0, r_sh[WIDTH-1:1]};
      assign w_out_bit    = r_sh[0];
    end
  endgenerate

  assign w_word_ready = !r_hold_full && !bus.flush;
  assign w_accept     = bus.word_valid && w_word_ready;
  assign w_last       = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sh_nxt        = r_sh;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;

    if (bus.flush) begin
      // Flush wins over reload and accept; word_ready is already low here.
      w_state_nxt     = S_IDLE;
      w_sh_nxt        = '0;
      w_cnt_nxt       = '0;
      w_hold_full_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_hold_full) begin
            w_state_nxt     = S_SHIFT;
            w_sh_nxt        = r_hold;
            w_cnt_nxt       = '0;
            w_hold_full_nxt = 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_last) begin
            if (r_hold_full) begin
              // Reload on the last bit so the next word follows with no gap.
              w_sh_nxt        = r_hold;
              w_cnt_nxt       = '0;
              w_hold_full_nxt = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_sh_nxt    = w_sh_shifted;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_sh_nxt  = w_sh_shifted;
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase

      // Accept only happens with the holding register empty, so it can
      // safely override a transfer that empties it on the same edge.
      if (w_accept) begin
        w_hold_nxt      = bus.word_in;
        w_hold_full_nxt = 1'b1;
      end
    end
  end

  assign bus.word_ready  = w_word_ready;
  assign bus.in_bit      = (r_state == S_SHIFT) ? w_out_bit : IDLE_BIT;
  assign bus.bit_valid   = (r_state == S_SHIFT);
  assign bus.frame_start = (r_state == S_SHIFT) && (r_cnt == '0);
  assign bus.frame_done  = (r_state == S_SHIFT) && w_last;
  assign bus.busy        = (r_state == S_SHIFT) || r_hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  localparam int  W = 8;
  localparam time P = 10;

  logic         clk        = 1'b0;
  logic         reset      = 1'b0;
  logic         word_valid = 1'b0;
  logic         flush      = 1'b0;
  logic [W-1:0] word_in    = '0;

  bit_serializer_if #(.WIDTH(W)) ifa ();
  bit_serializer_if #(.WIDTH(W)) ifb ();

  assign ifa.word_in    = word_in;
  assign ifa.word_valid = word_valid;
  assign ifa.flush      = flush;
  assign ifb.word_in    = word_in;
  assign ifb.word_valid = word_valid;
  assign ifb.flush      = flush;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  always #(P/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Capture of every emitted bit (negedge sampling).
  bit  cap_a[$];
  bit  cap_b[$];
  bit  cap_fs[$];
  bit  cap_fd[$];
  bit  cap_fs_b[$];
  time cap_t[$];

  always @(negedge clk) begin
    if (ifa.bit_valid === 1'b1) begin
      cap_a.push_back(ifa.in_bit);
      cap_fs.push_back(ifa.frame_start);
      cap_fd.push_back(ifa.frame_done);
      cap_t.push_back($time);
    end
    if (ifb.bit_valid === 1'b1) begin
      cap_b.push_back(ifb.in_bit);
      cap_fs_b.push_back(ifb.frame_start);
    end
  end

  // Edge events for the reference model.
  logic         acc_ev = 1'b0;
  logic         fl_ev  = 1'b0;
  logic [W-1:0] acc_word = '0;
  int           acc_count = 0;

  always @(posedge clk) begin
    acc_ev   <= reset && word_valid && ifa.word_ready;
    fl_ev    <= reset && flush;
    acc_word <= word_in;
    if (reset && word_valid && ifa.word_ready) acc_count <= acc_count + 1;
  end

  // Reference model: queues of bits still owed to the detector, in send order.
  bit exp_a[$];
  bit exp_b[$];
  int pos = 0;

  task automatic sb_step();
    int  p;
    bit  e;
    if (fl_ev) begin
      exp_a.delete();
      exp_b.delete();
      pos = 0;
    end else if (acc_ev) begin
      for (int i = W-1; i >= 0; i--) exp_a.push_back(acc_word[i]);
      for (int i = 0; i < W; i++)    exp_b.push_back(acc_word[i]);
    end
    chk("sb_busy_a", ifa.busy, exp_a.size() != 0);
    chk("sb_busy_b", ifb.busy, exp_b.size() != 0);
    if (acc_ev) chk("sb_ready_drop", ifa.word_ready, 0);
    p = pos;
    if (ifa.bit_valid) begin
      if (exp_a.size() == 0) chk("sb_extra_bit_a", ifa.bit_valid, 0);
      else begin
        e = exp_a.pop_front();
        chk("sb_bit_a", ifa.in_bit, e);
        chk("sb_fs_a", ifa.frame_start, p == 0);
        chk("sb_fd_a", ifa.frame_done, p == W-1);
      end
    end else begin
      chk("sb_idle_a", ifa.in_bit, 0);
      chk("sb_idle_fs_a", ifa.frame_start, 0);
    end
    if (ifb.bit_valid) begin
      if (exp_b.size() == 0) chk("sb_extra_bit_b", ifb.bit_valid, 0);
      else begin
        e = exp_b.pop_front();
        chk("sb_bit_b", ifb.in_bit, e);
        chk("sb_fd_b", ifb.frame_done, p == W-1);
      end
    end else begin
      chk("sb_idle_b", ifb.in_bit, 0);
    end
    if (ifa.bit_valid || ifb.bit_valid) pos = (p + 1) % W;
  endtask

  function automatic logic [31:0] pack(input bit q[$], input int base, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (base + i < q.size()) ? q[base + i] : 1'b0};
    return v;
  endfunction

  // Offer a word from a negedge; returns at the negedge right after the accepting edge.
  task automatic offer(input logic [W-1:0] w, output time t_acc, output int waits);
    bit ok = 1'b0;
    waits = 0;
    word_in    = w;
    word_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      #1;
      if (ifa.word_ready === 1'b1) ok = 1'b1;
      else waits++;
      @(negedge clk);
    end
    word_valid = 1'b0;
    t_acc = $time;
    chk("offer_accepted", ok, 1);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_msb;  // send order, [W-1] first
    logic [W-1:0] exp_lsb;
  } vec_t;

  vec_t vecs[7];
  time  t_acc;
  int   waits, base, base_b, n, a0;

  initial begin
    vecs[0] = '{8'b0011_0110, 8'b0011_0110, 8'b0110_1100};
    vecs[1] = '{8'hC3,        8'b1100_0011, 8'b1100_0011};
    vecs[2] = '{8'b0000_0011, 8'b0000_0011, 8'b1100_0000};
    vecs[3] = '{8'hA5,        8'b1010_0101, 8'b1010_0101};
    vecs[4] = '{8'h80,        8'b1000_0000, 8'b0000_0001};
    vecs[5] = '{8'h5A,        8'b0101_1010, 8'b0101_1010};
    vecs[6] = '{8'h1E,        8'b0001_1110, 8'b0111_1000};

    // Reset values, no clock edge yet.
    #2;
    chk("rst_ready",   ifa.word_ready, 1);
    chk("rst_in_bit",  ifa.in_bit, 0);
    chk("rst_bv",      ifa.bit_valid, 0);
    chk("rst_fs",      ifa.frame_start, 0);
    chk("rst_fd",      ifa.frame_done, 0);
    chk("rst_busy",    ifa.busy, 0);
    chk("rst_in_bit_b", ifb.in_bit, 0);
    chk("rst_busy_b",  ifb.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_neg(2);

    // Table: single words, both bit orders.
    for (int v = 0; v < 7; v++) begin
      base   = cap_a.size();
      base_b = cap_b.size();
      offer(vecs[v].word, t_acc, waits);
      wait_neg(11);
      chk($sformatf("v%0d_nbits", v), cap_a.size() - base, W);
      chk($sformatf("v%0d_msb_bits", v), pack(cap_a, base, W), vecs[v].exp_msb);
      chk($sformatf("v%0d_lsb_bits", v), pack(cap_b, base_b, W), vecs[v].exp_lsb);
      chk($sformatf("v%0d_fs", v), pack(cap_fs, base, W), 8'h80);
      chk($sformatf("v%0d_fd", v), pack(cap_fd, base, W), 8'h01);
      chk($sformatf("v%0d_fs_b", v), pack(cap_fs_b, base_b, W), 8'h80);
      chk($sformatf("v%0d_latency", v),
          (cap_t.size() > base) ? 32'(cap_t[base] - t_acc) : 32'hFFFF_FFFF, P);
      chk($sformatf("v%0d_after_bv", v), ifa.bit_valid, 0);
      chk($sformatf("v%0d_after_bit", v), ifa.in_bit, 0);
      chk($sformatf("v%0d_after_busy", v), ifa.busy, 0);
      chk($sformatf("v%0d_after_ready", v), ifa.word_ready, 1);
    end

    // Back-to-back C3, 5A: 16 gapless bits.
    base = cap_a.size();
    base_b = cap_b.size();
    offer(8'hC3, t_acc, waits);
    a0 = int'(t_acc);
    offer(8'h5A, t_acc, waits);
    wait_neg(20);
    chk("b2b_nbits", cap_a.size() - base, 16);
    chk("b2b_bits", pack(cap_a, base, 16), 16'hC35A);
    chk("b2b_bits_b", pack(cap_b, base_b, 16), 16'hC35A);
    chk("b2b_fs", pack(cap_fs, base, 16), 16'h8080);
    chk("b2b_fd", pack(cap_fd, base, 16), 16'h0101);
    chk("b2b_span", (cap_t.size() >= base + 16) ? 32'(cap_t[base+15] - cap_t[base]) : 0, 15*P);
    chk("b2b_latency", (cap_t.size() > base) ? 32'(cap_t[base]) - 32'(a0) : 0, P);

    // Backpressure with three queued words.
    base = cap_a.size();
    base_b = cap_b.size();
    a0 = acc_count;
    offer(8'h11, t_acc, waits);
    #1;
    chk("bp_ready_drop", ifa.word_ready, 0);
    offer(8'h22, t_acc, waits);
    offer(8'h33, t_acc, waits);
    chk("bp_stalled", waits > 0, 1);
    wait_neg(30);
    chk("bp_accepts", acc_count - a0, 3);
    chk("bp_nbits", cap_a.size() - base, 24);
    chk("bp_order", pack(cap_a, base, 24), 24'h112233);
    chk("bp_order_b", pack(cap_b, base_b, 24), 24'h8844CC);

    // Flush on the 4th bit of FF with 0F pending.
    base = cap_a.size();
    base_b = cap_b.size();
    offer(8'hFF, t_acc, waits);
    offer(8'h0F, t_acc, waits);
    #1;
    n = 0;
    while ((cap_a.size() - base) < 4 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("flush_reach_bit4", cap_a.size() - base, 4);
    flush = 1'b1;
    #1;
    chk("flush_ready_low", ifa.word_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_bv", ifa.bit_valid, 0);
    chk("flush_busy", ifa.busy, 0);
    chk("flush_in_bit", ifa.in_bit, 0);
    chk("flush_ready_back", ifa.word_ready, 1);
    wait_neg(20);
    chk("flush_nbits", cap_a.size() - base, 4);
    chk("flush_bits", pack(cap_a, base, 4), 4'hF);
    chk("flush_nbits_b", cap_b.size() - base_b, 4);

    // Async reset on the 3rd bit of A5, then 3C.
    base = cap_a.size();
    offer(8'hA5, t_acc, waits);
    #1;
    n = 0;
    while ((cap_a.size() - base) < 3 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_in_bit", ifa.in_bit, 0);
    chk("arst_busy", ifa.busy, 0);
    chk("arst_bv", ifa.bit_valid, 0);
    chk("arst_ready", ifa.word_ready, 1);
    chk("arst_busy_b", ifb.busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_partial_bits", cap_a.size() - base, 3);
    base = cap_a.size();
    base_b = cap_b.size();
    offer(8'h3C, t_acc, waits);
    wait_neg(12);
    chk("arst_3c_nbits", cap_a.size() - base, W);
    chk("arst_3c_bits", pack(cap_a, base, W), 8'h3C);
    chk("arst_3c_bits_b", pack(cap_b, base_b, W), 8'h3C);
    chk("arst_3c_latency", (cap_t.size() > base) ? 32'(cap_t[base] - t_acc) : 0, P);

    // Randomized stream against the queue model.
    pos = 0;
    for (int c = 0; c < 600; c++) begin
      sb_step();
      word_valid = ($urandom_range(0, 9) < 7);
      word_in    = W'($urandom);
      flush      = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    word_valid = 1'b0;
    flush      = 1'b0;
    for (int c = 0; c < 30; c++) begin
      sb_step();
      @(negedge clk);
    end
    chk("rand_drained_a", exp_a.size(), 0);
    chk("rand_drained_b", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(P * 20000);
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
